// File: rtl/permutation_iter.sv
// permutation_iter: iterative Ascon permutation, one full round per clock.
//   Shared types (permutation_iter_pkg), the linear diffusion layer
//   (diffusion_layer) and the round-iterating top (permutation_iter).
//
// permutation_iter ports
//   clock_i        rising-edge clock
//   resetb_i       asynchronous active-low reset
//   start_i        load request, honoured in IDLE or DONE only
//   mode_i         0 = p^a (ROUNDS_A rounds), 1 = p^b (ROUNDS_B rounds)
//   state_i        initial 320-bit state, sampled with start_i
//   xor_begin_i    at load, x0 ^= data_i
//   data_i         64-bit word for the begin XOR
//   xor_end_key_i  on the final round, x3/x4 ^= key_i
//   xor_end_one_i  on the final round, x4[0] ^= 1 (after the key XOR)
//   key_i          128-bit key for the end XOR
//   state_o        current state register
//   busy_o         high while rounds execute
//   done_o         one-cycle completion pulse
//   round_o        index of the round executing this cycle (12 once done)

package permutation_iter_pkg;

   localparam int unsigned WORD_W       = 64;
   localparam int unsigned KEY_W        = 128;
   localparam int unsigned ROUND_W      = 4;
   localparam int unsigned TOTAL_ROUNDS = 12;
   localparam int unsigned LAST_ROUND   = TOTAL_ROUNDS - 1;

   // x0 occupies the most significant word of the packed state
   typedef struct packed {
      logic [WORD_W-1:0] x0;
      logic [WORD_W-1:0] x1;
      logic [WORD_W-1:0] x2;
      logic [WORD_W-1:0] x3;
      logic [WORD_W-1:0] x4;
   } type_state;

endpackage

// diffusion_layer: Ascon linear layer, xi ^= ror(xi,a) ^ ror(xi,b).
//   state_i  substituted state
//   state_c  diffused state (combinational)
module diffusion_layer
   import permutation_iter_pkg::*;
(
   input  type_state state_i,
   output type_state state_c
);

   always_comb begin
      state_c    = state_i;
      state_c.x0 = state_i.x0 ^ {state_i.x0[18:0], state_i.x0[63:19]}
                              ^ {state_i.x0[27:0], state_i.x0[63:28]};
      state_c.x1 = state_i.x1 ^ {state_i.x1[60:0], state_i.x1[63:61]}
                              ^ {state_i.x1[38:0], state_i.x1[63:39]};
      state_c.x2 = state_i.x2 ^ {state_i.x2[0],    state_i.x2[63:1]}
                              ^ {state_i.x2[5:0],  state_i.x2[63:6]};
      state_c.x3 = state_i.x3 ^ {state_i.x3[9:0],  state_i.x3[63:10]}
                              ^ {state_i.x3[16:0], state_i.x3[63:17]};
      state_c.x4 = state_i.x4 ^ {state_i.x4[6:0],  state_i.x4[63:7]}
                              ^ {state_i.x4[40:0], state_i.x4[63:41]};
   end

endmodule

module permutation_iter
   import permutation_iter_pkg::*;
#(
   parameter int unsigned ROUNDS_A = 12,
   parameter int unsigned ROUNDS_B = 6
)(
   input  logic               clock_i,
   input  logic               resetb_i,
   input  logic               start_i,
   input  logic               mode_i,
   input  type_state          state_i,
   input  logic               xor_begin_i,
   input  logic [WORD_W-1:0]  data_i,
   input  logic               xor_end_key_i,
   input  logic               xor_end_one_i,
   input  logic [KEY_W-1:0]   key_i,
   output type_state          state_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [ROUND_W-1:0] round_o
);

   // Shorter permutations skip the leading rounds so the constants stay aligned
   localparam logic [ROUND_W-1:0] START_A = ROUND_W'(TOTAL_ROUNDS - ROUNDS_A);
   localparam logic [ROUND_W-1:0] START_B = ROUND_W'(TOTAL_ROUNDS - ROUNDS_B);
   localparam logic [ROUND_W-1:0] LAST    = ROUND_W'(LAST_ROUND);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t               fsm_q;
   type_state          state_q;
   logic [ROUND_W-1:0] round_q;
   logic               end_key_q;
   logic               end_one_q;
   logic [KEY_W-1:0]   key_q;
   logic               busy_q;
   logic               done_q;

   logic [7:0]         rc_c;
   type_state          add_c;
   type_state          sub_c;
   type_state          diff_c;
   type_state          fin_c;
   type_state          load_c;
   logic [4:0]         col_c;

   // Ascon 5-bit S-box, index bit 4 = x0
   function automatic logic [4:0] sbox(input logic [4:0] v);
      logic [4:0] r;
      case (v)
         5'h00: r = 5'h04;  5'h01: r = 5'h0B;  5'h02: r = 5'h1F;  5'h03: r = 5'h14;
         5'h04: r = 5'h1A;  5'h05: r = 5'h15;  5'h06: r = 5'h09;  5'h07: r = 5'h02;
         5'h08: r = 5'h1B;  5'h09: r = 5'h05;  5'h0A: r = 5'h08;  5'h0B: r = 5'h12;
         5'h0C: r = 5'h1D;  5'h0D: r = 5'h03;  5'h0E: r = 5'h06;  5'h0F: r = 5'h1C;
         5'h10: r = 5'h1E;  5'h11: r = 5'h13;  5'h12: r = 5'h07;  5'h13: r = 5'h0E;
         5'h14: r = 5'h00;  5'h15: r = 5'h0D;  5'h16: r = 5'h11;  5'h17: r = 5'h18;
         5'h18: r = 5'h10;  5'h19: r = 5'h0C;  5'h1A: r = 5'h01;  5'h1B: r = 5'h19;
         5'h1C: r = 5'h16;  5'h1D: r = 5'h0A;  5'h1E: r = 5'h0F;  default: r = 5'h17;
      endcase
      return r;
   endfunction

   // Constant addition and bit-sliced substitution
   always_comb begin
      rc_c      = {ROUND_W'(4'hF - round_q), round_q};
      add_c     = state_q;
      add_c.x2  = {state_q.x2[63:8], state_q.x2[7:0] ^ rc_c};
      sub_c     = '0;
      col_c     = '0;
      for (int i = 0; i < 64; i++) begin
         col_c       = sbox({add_c.x0[i], add_c.x1[i], add_c.x2[i], add_c.x3[i], add_c.x4[i]});
         sub_c.x0[i] = col_c[4];
         sub_c.x1[i] = col_c[3];
         sub_c.x2[i] = col_c[2];
         sub_c.x3[i] = col_c[1];
         sub_c.x4[i] = col_c[0];
      end
   end

   diffusion_layer u_diffusion (
      .state_i (sub_c),
      .state_c (diff_c)
   );

   // End XORs only on the final round; the one-bit flip lands after the key
   always_comb begin
      fin_c = diff_c;
      if (round_q == LAST) begin
         if (end_key_q) begin
            fin_c.x3 = diff_c.x3 ^ key_q[127:64];
            fin_c.x4 = diff_c.x4 ^ key_q[63:0];
         end
         if (end_one_q) begin
            fin_c.x4[0] = fin_c.x4[0] ^ 1'b1;
         end
      end
   end

   // Initial state with optional begin XOR into x0
   always_comb begin
      load_c = state_i;
      if (xor_begin_i) begin
         load_c.x0 = state_i.x0 ^ data_i;
      end
   end

   // Control FSM, round counter and state register
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         fsm_q     <= IDLE;
         state_q   <= '0;
         round_q   <= '0;
         end_key_q <= 1'b0;
         end_one_q <= 1'b0;
         key_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  fsm_q     <= RUN;
                  state_q   <= load_c;
                  round_q   <= mode_i ? START_B : START_A;
                  end_key_q <= xor_end_key_i;
                  end_one_q <= xor_end_one_i;
                  key_q     <= key_i;
                  busy_q    <= 1'b1;
               end else begin
                  fsm_q  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            RUN: begin
               state_q <= fin_c;
               round_q <= round_q + ROUND_W'(1);
               if (round_q == LAST) begin
                  fsm_q  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               fsm_q  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign state_o = state_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign round_o = round_q;

endmodule

// File: tb/tb_permutation_iter.sv
// tb_permutation_iter: directed checks of permutation_iter against an
//   independent Ascon model (boolean S-box form, shift-based rotations).
module tb_permutation_iter;

   logic         clk;
   logic         resetb;
   logic         start;
   logic         mode;
   logic [319:0] state_in;
   logic         xor_begin;
   logic [63:0]  data;
   logic         xor_end_key;
   logic         xor_end_one;
   logic [127:0] key;
   logic [319:0] state_out;
   logic         busy;
   logic         done;
   logic [3:0]   round;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [127:0] KEY_SEQ   = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] NONCE_SEQ = 128'h101112131415161718191A1B1C1D1E1F;

   permutation_iter dut (
      .clock_i       (clk),
      .resetb_i      (resetb),
      .start_i       (start),
      .mode_i        (mode),
      .state_i       (state_in),
      .xor_begin_i   (xor_begin),
      .data_i        (data),
      .xor_end_key_i (xor_end_key),
      .xor_end_one_i (xor_end_one),
      .key_i         (key),
      .state_o       (state_out),
      .busy_o        (busy),
      .done_o        (done),
      .round_o       (round)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [319:0] mdl_round(input logic [319:0] s, input int r);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      logic [7:0]  rc;
      x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
      rc = 8'((15 - r) * 16 + r);
      x2[7:0] = x2[7:0] ^ rc;
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic logic [319:0] mdl_perm(input logic [319:0] s, input logic m,
                                             input logic xb, input logic [63:0] d,
                                             input logic xk, input logic xo,
                                             input logic [127:0] k);
      logic [319:0] v;
      v = s;
      if (xb) v[319:256] = v[319:256] ^ d;
      for (int r = (m ? 6 : 0); r < 12; r++) v = mdl_round(v, r);
      if (xk) v[127:0] = v[127:0] ^ k;
      if (xo) v[0] = ~v[0];
      return v;
   endfunction

   // Drive a start at the current negedge; returns at the negedge after the load edge
   task automatic load(input logic m, input logic [319:0] s, input logic xb,
                       input logic [63:0] d, input logic xk, input logic xo,
                       input logic [127:0] k);
      start = 1'b1; mode = m; state_in = s; xor_begin = xb; data = d;
      xor_end_key = xk; xor_end_one = xo; key = k;
      @(negedge clk);
      start = 1'b0; mode = 1'b0; state_in = '0; xor_begin = 1'b0; data = '0;
      xor_end_key = 1'b0; xor_end_one = 1'b0; key = '0;
   endtask

   // Counts clock edges (load edge = 1) until done_o is seen, bounded
   task automatic wait_done(input int start_edges, output int edges);
      edges = start_edges;
      while (done !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic test_reset;
      resetb = 1'b1;
      #2 resetb = 1'b0;
      #2;
      n_checks++; if (state_out !== '0) $display("FAIL reset_state: got %h expected 0", state_out); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
      n_checks++; if (round !== 4'd0) $display("FAIL reset_round: got %0d expected 0", round); else n_pass++;
      @(negedge clk);
      resetb = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_pa;
      logic [319:0] exp;
      exp = mdl_perm('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      load(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
      for (int r = 0; r < 12; r++) begin
         n_checks++; if (round !== 4'(r) || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL pa_round: got round=%0d busy=%b done=%b expected round=%0d busy=1 done=0", round, busy, done, r);
         else n_pass++;
         if (r == 1) begin
            n_checks++; if (state_out !== mdl_round('0, 0))
               $display("FAIL pa_first_round: got %h expected %h", state_out, mdl_round('0, 0));
            else n_pass++;
         end
         @(negedge clk);
      end
      n_checks++; if (done !== 1'b1 || busy !== 1'b0 || round !== 4'd12)
         $display("FAIL pa_done: got done=%b busy=%b round=%0d expected 1 0 12", done, busy, round);
      else n_pass++;
      n_checks++; if (state_out !== exp) $display("FAIL pa_final: got %h expected %h", state_out, exp); else n_pass++;
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || state_out !== exp)
         $display("FAIL pa_hold: got done=%b state=%h expected done=0 state=%h", done, state_out, exp);
      else n_pass++;
   endtask

   task automatic test_pb;
      logic [319:0] iv, exp;
      int e;
      iv  = {64'h80400C0600000000, KEY_SEQ, NONCE_SEQ};
      exp = mdl_perm(iv, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      load(1'b1, iv, 1'b0, '0, 1'b0, 1'b0, '0);
      n_checks++; if (round !== 4'd6) $display("FAIL pb_start_round: got %0d expected 6", round); else n_pass++;
      @(negedge clk);
      n_checks++; if (state_out !== mdl_round(iv, 6))
         $display("FAIL pb_first_round: got %h expected %h", state_out, mdl_round(iv, 6));
      else n_pass++;
      wait_done(2, e);
      n_checks++; if (e !== 7) $display("FAIL pb_latency: got %0d expected 7", e); else n_pass++;
      n_checks++; if (state_out !== exp) $display("FAIL pb_final: got %h expected %h", state_out, exp); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_xor;
      logic [319:0] s, exp, exp_plain;
      int e;
      s   = {64'hA5A5A5A55A5A5A5A, 64'h0F0F0F0FF0F0F0F0, 64'h1122334455667788,
             64'h99AABBCCDDEEFF00, 64'hDEADBEEFCAFEF00D};
      exp = mdl_perm(s, 1'b1, 1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b1, KEY_SEQ);
      exp_plain = mdl_perm(s, 1'b1, 1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b0, '0);
      load(1'b1, s, 1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b1, KEY_SEQ);
      n_checks++; if (state_out[319:256] !== (s[319:256] ^ 64'h0123456789ABCDEF))
         $display("FAIL xor_begin_load: got %h expected %h", state_out[319:256], s[319:256] ^ 64'h0123456789ABCDEF);
      else n_pass++;
      for (int i = 0; i < 5; i++) @(negedge clk);
      n_checks++; if (state_out !== mdl_round(mdl_round(mdl_round(mdl_round(mdl_round(
                      {s[319:256] ^ 64'h0123456789ABCDEF, s[255:0]}, 6), 7), 8), 9), 10))
         $display("FAIL xor_no_early_end: got %h", state_out);
      else n_pass++;
      wait_done(6, e);
      n_checks++; if (e !== 7) $display("FAIL xor_latency: got %0d expected 7", e); else n_pass++;
      n_checks++; if (state_out !== exp) $display("FAIL xor_final: got %h expected %h", state_out, exp); else n_pass++;
      n_checks++; if ((state_out ^ exp_plain) !== {192'd0, KEY_SEQ ^ 128'd1})
         $display("FAIL xor_end_delta: got %h expected %h", state_out ^ exp_plain, {192'd0, KEY_SEQ ^ 128'd1});
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_ignore;
      logic [319:0] s, exp;
      int e;
      s   = {64'h0000000000000001, 64'h2, 64'h3, 64'h4, 64'h5};
      exp = mdl_perm(s, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      load(1'b0, s, 1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; mode = 1'b1; state_in = {5{64'hFFFF0000FFFF0000}};
      xor_begin = 1'b1; data = 64'h1234; xor_end_key = 1'b1; xor_end_one = 1'b1; key = KEY_SEQ;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0; mode = 1'b0; state_in = '0; xor_begin = 1'b0; data = '0;
      xor_end_key = 1'b0; xor_end_one = 1'b0; key = '0;
      n_checks++; if (round !== 4'd4) $display("FAIL ignore_round: got %0d expected 4", round); else n_pass++;
      wait_done(5, e);
      n_checks++; if (e !== 13) $display("FAIL ignore_latency: got %0d expected 13", e); else n_pass++;
      n_checks++; if (state_out !== exp) $display("FAIL ignore_final: got %h expected %h", state_out, exp); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [319:0] s1, s2, exp1, exp2;
      int e;
      s1   = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
              64'h4444444444444444, 64'h5555555555555555};
      s2   = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001};
      exp1 = mdl_perm(s1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      exp2 = mdl_perm(s2, 1'b0, 1'b0, '0, 1'b1, 1'b0, KEY_SEQ);
      load(1'b1, s1, 1'b0, '0, 1'b0, 1'b0, '0);
      wait_done(1, e);
      n_checks++; if (e !== 7 || state_out !== exp1)
         $display("FAIL b2b_first: got edges=%0d state=%h expected 7 %h", e, state_out, exp1);
      else n_pass++;
      load(1'b0, s2, 1'b0, '0, 1'b1, 1'b0, KEY_SEQ);
      n_checks++; if (busy !== 1'b1 || done !== 1'b0 || round !== 4'd0 || state_out !== s2)
         $display("FAIL b2b_reload: got busy=%b done=%b round=%0d state=%h expected 1 0 0 %h",
                  busy, done, round, state_out, s2);
      else n_pass++;
      wait_done(1, e);
      n_checks++; if (e !== 13) $display("FAIL b2b_latency: got %0d expected 13", e); else n_pass++;
      n_checks++; if (state_out !== exp2) $display("FAIL b2b_final: got %h expected %h", state_out, exp2); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_midrun;
      int k;
      load(1'b0, {5{64'hC3C3C3C3C3C3C3C3}}, 1'b0, '0, 1'b1, 1'b1, KEY_SEQ);
      k = 0;
      while (round !== 4'd5 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_checks++; if (round !== 4'd5 || busy !== 1'b1)
         $display("FAIL midrun_reach: got round=%0d busy=%b expected 5 1", round, busy);
      else n_pass++;
      #2 resetb = 1'b0;
      #1;
      n_checks++; if (state_out !== '0 || busy !== 1'b0 || done !== 1'b0 || round !== 4'd0)
         $display("FAIL midrun_async: got state=%h busy=%b done=%b round=%0d expected 0 0 0 0",
                  state_out, busy, done, round);
      else n_pass++;
      @(negedge clk);
      resetb = 1'b1;
      for (int i = 0; i < 3; i++) @(negedge clk);
      n_checks++; if (state_out !== '0 || busy !== 1'b0 || done !== 1'b0 || round !== 4'd0)
         $display("FAIL midrun_idle: got state=%h busy=%b done=%b round=%0d expected 0 0 0 0",
                  state_out, busy, done, round);
      else n_pass++;
   endtask

   initial begin
      resetb = 1'b1; start = 1'b0; mode = 1'b0; state_in = '0; xor_begin = 1'b0;
      data = '0; xor_end_key = 1'b0; xor_end_one = 1'b0; key = '0;
      test_reset;
      test_pa;
      test_pb;
      test_xor;
      test_ignore;
      test_back_to_back;
      test_reset_midrun;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
